// File: rtl/wb_reg_slave_pkg.sv
// Shared types and sizing helpers for the Wishbone register slave.
package wb_reg_slave_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_e;

    localparam int unsigned WAIT_CNT_W  = 3;
    localparam int unsigned WRITE_CNT_W = 16;

    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/wb_reg_array.sv
// Register file with async-low clear, one write port, one registered read port
// and a per-entry written mask.
module wb_reg_array
    import wb_reg_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_COUNT = 16,
    parameter int unsigned IDX_W      = idx_width(DATA_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  rd_hit_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [DATA_COUNT-1:0] written_o
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_COUNT];
    logic [DATA_COUNT-1:0] written_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DATA_COUNT); i++) begin
                mem_q[i] <= '0;
            end
            written_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i]     <= wr_data_i;
            written_q[wr_idx_i] <= 1'b1;
        end
    end

    // Out-of-range reads still complete, returning zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_hit_i ? mem_q[rd_idx_i] : '0;
        end
    end

    assign rd_data_o = rd_data_q;
    assign written_o = written_q;

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone classic slave fronting a register array, with programmable wait
// states and write-progress reporting.
module wb_reg_slave
    import wb_reg_slave_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           DATA_COUNT   = 16,
    parameter int unsigned           WAIT_STATES  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic                   we_i,
    input  logic [ADDR_WIDTH-1:0]  adr_i,
    input  logic [DATA_WIDTH-1:0]  dat_i,
    output logic                   ack_o,
    output logic [DATA_WIDTH-1:0]  dat_o,
    output logic [WRITE_CNT_W-1:0] write_count,
    output logic                   all_written
);

    localparam int unsigned           IDX_W     = idx_width(DATA_COUNT);
    localparam logic [ADDR_WIDTH-1:0] COUNT_A   = ADDR_WIDTH'(DATA_COUNT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_e                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   req_we_q, req_hit_q;
    logic [IDX_W-1:0]       req_idx_q;
    logic [DATA_WIDTH-1:0]  req_dat_q;
    logic [WRITE_CNT_W-1:0] write_count_q;
    logic                   all_written_q;

    logic [ADDR_WIDTH-1:0]  idx_full;
    logic                   in_range;
    logic                   accept;
    logic                   enter_ack;
    logic                   acc_we, acc_hit;
    logic [IDX_W-1:0]       acc_idx;
    logic [DATA_WIDTH-1:0]  acc_dat;
    logic                   wr_en, rd_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DATA_COUNT-1:0]  written;

    // idx wraps for addresses below the base; the >= test rejects those.
    assign idx_full = adr_i - BASE_ADDRESS;
    assign in_range = (adr_i >= BASE_ADDRESS) && (idx_full < COUNT_A);
    assign accept   = (state_q == StIdle) && cyc_i && stb_i;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StIdle: begin
                if (cyc_i && stb_i) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            StWait: begin
                if (!cyc_i) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we_q  <= 1'b0;
            req_hit_q <= 1'b0;
            req_idx_q <= '0;
            req_dat_q <= '0;
        end else if (accept) begin
            req_we_q  <= we_i;
            req_hit_q <= in_range;
            req_idx_q <= idx_full[IDX_W-1:0];
            req_dat_q <= dat_i;
        end
    end

    // With zero wait states the access happens on the accepting edge, before
    // the request registers are loaded, so use the live bus instead.
    always_comb begin
        acc_we  = req_we_q;
        acc_hit = req_hit_q;
        acc_idx = req_idx_q;
        acc_dat = req_dat_q;
        if (state_q == StIdle) begin
            acc_we  = we_i;
            acc_hit = in_range;
            acc_idx = idx_full[IDX_W-1:0];
            acc_dat = dat_i;
        end
    end

    assign enter_ack = (state_d == StAck) && (state_q != StAck);
    assign wr_en     = enter_ack && acc_we && acc_hit;
    assign rd_en     = enter_ack && !acc_we;

    wb_reg_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_COUNT (DATA_COUNT),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (wr_en),
        .wr_idx_i  (acc_idx),
        .wr_data_i (acc_dat),
        .rd_en_i   (rd_en),
        .rd_hit_i  (acc_hit),
        .rd_idx_i  (acc_idx),
        .rd_data_o (rd_data),
        .written_o (written)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_count_q <= '0;
            all_written_q <= 1'b0;
        end else begin
            if (wr_en && (write_count_q != '1)) begin
                write_count_q <= write_count_q + 1'b1;
            end
            all_written_q <= all_written_q | (&written);
        end
    end

    assign ack_o       = (state_q == StAck);
    assign dat_o       = rd_data;
    assign write_count = write_count_q;
    assign all_written = all_written_q;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Three slaves (1, 3 and 0 wait states) at base 64, checked against an array model.
module tb_wb_reg_slave;

    localparam logic [31:0] BASE  = 32'd64;
    localparam int          COUNT = 16;

    logic        clk, rst;
    logic [2:0]  cyc, stb, we, ack, allw;
    logic [31:0] adr   [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic [15:0] wcnt  [3];

    int ws_of [3] = '{1, 3, 0};

    logic [31:0] mem_m  [3][COUNT];
    logic [15:0] mask_m [3];
    int          cnt_m  [3];

    int n_vec = 0;
    int n_err = 0;

    wb_reg_slave #(
        .ADDR_WIDTH(32), .BASE_ADDRESS(BASE), .DATA_WIDTH(32), .DATA_COUNT(COUNT), .WAIT_STATES(1)
    ) u_dut_ws1 (
        .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .adr_i(adr[0]),
        .dat_i(dat_w[0]), .ack_o(ack[0]), .dat_o(dat_r[0]), .write_count(wcnt[0]),
        .all_written(allw[0])
    );

    wb_reg_slave #(
        .ADDR_WIDTH(32), .BASE_ADDRESS(BASE), .DATA_WIDTH(32), .DATA_COUNT(COUNT), .WAIT_STATES(3)
    ) u_dut_ws3 (
        .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .adr_i(adr[1]),
        .dat_i(dat_w[1]), .ack_o(ack[1]), .dat_o(dat_r[1]), .write_count(wcnt[1]),
        .all_written(allw[1])
    );

    wb_reg_slave #(
        .ADDR_WIDTH(32), .BASE_ADDRESS(BASE), .DATA_WIDTH(32), .DATA_COUNT(COUNT), .WAIT_STATES(0)
    ) u_dut_ws0 (
        .clk(clk), .rst(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]), .adr_i(adr[2]),
        .dat_i(dat_w[2]), .ack_o(ack[2]), .dat_o(dat_r[2]), .write_count(wcnt[2]),
        .all_written(allw[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit full_m(input int d);
        return &mask_m[d];
    endfunction

    function automatic bit hit_m(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(COUNT));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < COUNT; i++) mem_m[d][i] = '0;
            mask_m[d] = '0;
            cnt_m[d]  = 0;
        end
    endtask

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] v);
        if (hit_m(a)) begin
            mem_m[d][int'(a - BASE)]  = v;
            mask_m[d][int'(a - BASE)] = 1'b1;
            if (cnt_m[d] < 65535) cnt_m[d]++;
        end
    endtask

    // One classic single cycle: latency, read data, single-cycle ack, counters.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] v);
        int          n;
        logic [31:0] exp_rd;
        exp_rd = (!w && hit_m(a)) ? mem_m[d][int'(a - BASE)] : 32'd0;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = v;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack[d] && n < 20);
        check("ack_latency", n, ws_of[d] + 1);
        if (!w) check("read_data", dat_r[d], exp_rd);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        if (w) model_write(d, a, v);
        @(posedge clk); #1;
        check("ack_single", ack[d], 1'b0);
        check("write_count", wcnt[d], cnt_m[d]);
        check("all_written", allw[d], full_m(d));
    endtask

    // Master keeps cyc/stb high and moves to the next request as soon as it sees ack.
    task automatic b2b_writes(input logic [31:0] a_list[$], input logic [31:0] v_list[$]);
        int n_req, seen, cyc_n;
        bit prev_ack, prev_full;
        n_req = a_list.size();
        seen = 0; cyc_n = 0; prev_ack = 1'b0;
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = a_list[0]; dat_w[2] = v_list[0];
        prev_full = full_m(2);
        while (seen < n_req && cyc_n < 4 * n_req) begin
            @(posedge clk); #1;
            cyc_n++;
            check("b2b_all_written", allw[2], prev_full);
            check("b2b_ack_gap", prev_ack & ack[2], 1'b0);
            if (ack[2]) begin
                model_write(2, a_list[seen], v_list[seen]);
                seen++;
                if (seen < n_req) begin
                    adr[2] = a_list[seen]; dat_w[2] = v_list[seen];
                end else begin
                    cyc[2] = 1'b0; stb[2] = 1'b0;
                end
            end
            prev_ack  = ack[2];
            prev_full = full_m(2);
        end
        check("b2b_acks", seen, n_req);
        check("b2b_cycles", cyc_n, 2 * n_req - 1);
        @(posedge clk); #1;
        check("b2b_write_count", wcnt[2], cnt_m[2]);
        check("b2b_all_written_hold", allw[2], full_m(2));
    endtask

    initial begin
        logic [31:0] a_list[$];
        logic [31:0] v_list[$];
        int          n_ack;

        rst = 1'b0; cyc = '0; stb = '0; we = '0;
        for (int d = 0; d < 3; d++) begin
            adr[d] = '0; dat_w[d] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_ack", ack[d], 1'b0);
            check("rst_dat", dat_r[d], 32'd0);
            check("rst_wcnt", wcnt[d], 16'd0);
            check("rst_allw", allw[d], 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Basic write/read, one wait state.
        xfer(0, 1'b1, 32'd66, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'd66, 32'd0);

        // Out-of-range on both sides of the window.
        xfer(0, 1'b1, 32'd80, $urandom);
        xfer(0, 1'b1, 32'd63, $urandom);
        xfer(0, 1'b0, 32'd80, 32'd0);
        xfer(0, 1'b0, 32'd63, 32'd0);
        xfer(0, 1'b0, 32'd66, 32'd0);

        // Abort a 3-wait-state write in its second wait cycle.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd64; dat_w[1] = $urandom | 32'h1;
        n_ack = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack[1]) n_ack++;
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[1]) n_ack++;
        end
        check("abort_no_ack", n_ack, 0);
        xfer(1, 1'b0, 32'd64, 32'd0);

        // Zero wait states, back-to-back fill of every index then a repeat of index 3.
        for (int i = 0; i < COUNT; i++) begin
            a_list.push_back(BASE + 32'(i));
            v_list.push_back(32'(i));
        end
        a_list.push_back(BASE + 32'd3);
        v_list.push_back($urandom);
        b2b_writes(a_list, v_list);
        check("repeat_mask", mask_m[2], 16'hFFFF);
        xfer(2, 1'b0, BASE + 32'd3, 32'd0);
        xfer(2, 1'b0, BASE + 32'd15, 32'd0);

        // Randomised traffic across all three slaves.
        repeat (120) begin
            int          d;
            bit          w;
            logic [31:0] a;
            d = $urandom_range(0, 2);
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(56, 84));
            xfer(d, w, a, $urandom);
        end

        // Asynchronous reset while a write sits in its wait states.
        xfer(1, 1'b1, 32'd70, 32'h1234_5678);
        xfer(1, 1'b0, 32'd70, 32'd0);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'd70; dat_w[1] = $urandom;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        check("arst_ack", ack[1], 1'b0);
        check("arst_dat", dat_r[1], 32'd0);
        check("arst_wcnt", wcnt[1], 16'd0);
        check("arst_allw", allw[1], 1'b0);
        check("arst_allw_ws0", allw[2], 1'b0);
        check("arst_wcnt_ws0", wcnt[2], 16'd0);
        model_reset();
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        xfer(1, 1'b0, 32'd70, 32'd0);
        xfer(2, 1'b0, BASE + 32'd3, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
